// File: rtl/sobel_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sobel_readout_ctrl
// Brief    : Sequences a sobel_exc frame, then streams the output memory back
//            through a 2-entry FIFO with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_readout_ctrl #(
   parameter int DATA_WIDTH        = 8,
   parameter int ADDR_WIDTH        = 16,
   parameter int IMAGE_ROW_SIZE    = 64,
   parameter int IMAGE_COLUMN_SIZE = 64,
   parameter int PIXEL_COUNT       = IMAGE_ROW_SIZE * IMAGE_COLUMN_SIZE,
   parameter int DRAIN_CYCLES      = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic                  sobel_start_o,
   input  logic                  sobel_finish_i,
   input  logic                  sobel_wr_en_i,
   input  logic [ADDR_WIDTH-1:0] sobel_addr_i,
   output logic                  mem_wr_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   output logic                  px_valid_o,
   input  logic                  px_ready_i,
   output logic [DATA_WIDTH-1:0] px_data_o,
   output logic                  px_last_o
);

   localparam logic [2:0] c_idle    = 3'd0;
   localparam logic [2:0] c_process = 3'd1;
   localparam logic [2:0] c_drain   = 3'd2;
   localparam logic [2:0] c_read    = 3'd3;
   localparam logic [2:0] c_done    = 3'd4;

   localparam int c_drain_w = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [c_drain_w-1:0]  c_drain_last = c_drain_w'(DRAIN_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] c_last_addr  = ADDR_WIDTH'(PIXEL_COUNT - 1);

   logic [2:0]            r_state;
   logic [2:0]            w_state_nxt;
   logic [c_drain_w-1:0]  r_drain_cnt;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic                  r_rd_all;
   logic                  r_inflight;
   logic [DATA_WIDTH-1:0] r_fifo_mem [0:1];
   logic                  r_fifo_wr_ptr;
   logic                  r_fifo_rd_ptr;
   logic [1:0]            r_fifo_cnt;
   logic [ADDR_WIDTH-1:0] r_px_cnt;
   logic                  r_err;

   logic                  w_sobel_owns;
   logic                  w_valid;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_last;
   logic [2:0]            w_occ;
   logic                  w_issue;

   assign w_sobel_owns = (r_state == c_process) || (r_state == c_drain);
   assign w_valid      = (r_fifo_cnt != 2'd0);
   assign w_pop        = w_valid && px_ready_i;
   assign w_push       = r_inflight;
   assign w_last       = w_valid && (r_px_cnt == c_last_addr);
   assign w_occ        = {1'b0, r_fifo_cnt} + {2'b00, r_inflight};
   // A same-cycle pop frees a slot, which is what sustains one pixel per cycle.
   assign w_issue      = (r_state == c_read) && !r_rd_all &&
                         (w_occ < (3'd2 + {2'b00, w_pop}));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_idle:    if (start_i)                        w_state_nxt = c_process;
         c_process: if (sobel_finish_i)                 w_state_nxt = c_drain;
         c_drain:   if (r_drain_cnt == c_drain_last)    w_state_nxt = c_read;
         c_read:    if (w_pop && w_last)                w_state_nxt = c_done;
         c_done:                                        w_state_nxt = c_idle;
         default:                                       w_state_nxt = c_idle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= c_idle;
         r_drain_cnt   <= '0;
         r_rd_addr     <= '0;
         r_rd_all      <= 1'b0;
         r_inflight    <= 1'b0;
         r_fifo_wr_ptr <= 1'b0;
         r_fifo_rd_ptr <= 1'b0;
         r_fifo_cnt    <= 2'd0;
         r_px_cnt      <= '0;
         r_err         <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (r_state == c_drain) r_drain_cnt <= r_drain_cnt + c_drain_w'(1);
         else                    r_drain_cnt <= '0;

         if (r_state == c_done) begin
            r_rd_addr <= '0;
            r_rd_all  <= 1'b0;
         end else if (w_issue) begin
            if (r_rd_addr == c_last_addr) r_rd_all  <= 1'b1;
            else                          r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
         end

         r_inflight <= w_issue;

         if (w_push) begin
            r_fifo_mem[r_fifo_wr_ptr] <= mem_data_i;
            r_fifo_wr_ptr             <= ~r_fifo_wr_ptr;
         end
         if (w_pop) r_fifo_rd_ptr <= ~r_fifo_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase

         if (r_state == c_done) r_px_cnt <= '0;
         else if (w_pop)        r_px_cnt <= r_px_cnt + ADDR_WIDTH'(1);

         if (sobel_wr_en_i && ((r_state == c_read) || (r_state == c_done)))
            r_err <= 1'b1;
      end
   end

   assign busy_o        = (r_state != c_idle);
   assign done_o        = (r_state == c_done);
   assign err_o         = r_err;
   assign sobel_start_o = (r_state == c_process);
   assign mem_wr_en_o   = w_sobel_owns && sobel_wr_en_i;
   assign mem_addr_o    = w_sobel_owns ? sobel_addr_i : r_rd_addr;
   assign px_valid_o    = w_valid;
   assign px_data_o     = w_valid ? r_fifo_mem[r_fifo_rd_ptr] : '0;
   assign px_last_o     = w_last;

endmodule
`default_nettype wire

// File: tb/tb_sobel_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_readout_ctrl
// Brief    : Directed self-checking bench for sobel_readout_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_readout_ctrl;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int PC = 16;
   localparam int DC = 2;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic          busy_o, done_o, err_o, sobel_start_o;
   logic          sobel_finish_i, sobel_wr_en_i;
   logic [AW-1:0] sobel_addr_i;
   logic          mem_wr_en_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_data_i;
   logic          px_valid_o, px_ready_i, px_last_o;
   logic [DW-1:0] px_data_o;

   logic [7:0] mem [0:15];
   logic [7:0] exp_px [0:15];
   logic       mem_load;
   logic [7:0] sobel_data;
   int         n_vec = 0;
   int         n_bad = 0;

   always #5 clk_i = ~clk_i;

   sobel_readout_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIXEL_COUNT(PC), .DRAIN_CYCLES(DC)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o),
      .done_o(done_o), .err_o(err_o), .sobel_start_o(sobel_start_o),
      .sobel_finish_i(sobel_finish_i), .sobel_wr_en_i(sobel_wr_en_i),
      .sobel_addr_i(sobel_addr_i), .mem_wr_en_o(mem_wr_en_o),
      .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
      .px_valid_o(px_valid_o), .px_ready_i(px_ready_i),
      .px_data_o(px_data_o), .px_last_o(px_last_o)
   );

   // Output memory: synchronous write, one-cycle read latency.
   always @(posedge clk_i) begin
      if (mem_load) for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
      else if (mem_wr_en_o) mem[mem_addr_o[3:0]] <= sobel_data;
      mem_data_i <= mem[mem_addr_o[3:0]];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("rst_ctrl", 32'({busy_o, done_o, err_o, sobel_start_o, mem_wr_en_o,
                           px_valid_o, px_last_o}), 32'd0);
      chk("rst_addr", 32'(mem_addr_o), 32'd0);
      chk("rst_data", 32'(px_data_o), 32'd0);
      rst_i = 1'b0;
   endtask

   task automatic run_frame(input int mode, input bit hold, input bit wr_rd,
                            input int abort_at, input int n_proc);
      int t, c, acc, first, lastc, maxo, d, nstart, restart;
      bit stl;
      logic [7:0] pd;
      t = 0;
      while (!busy_o && t < 8) begin @(negedge clk_i); t++; end
      chk("enter_proc", 32'(busy_o), 32'd1);
      if (!hold) start_i = 1'b0;
      nstart = 0;
      for (int k = 1; k <= n_proc; k++) begin
         nstart += int'(sobel_start_o);
         if (k == 3) begin
            sobel_wr_en_i = 1'b1; sobel_addr_i = 8'd5; sobel_data = 8'hA5;
            #1;
            chk("proc_wr_en", 32'(mem_wr_en_o), 32'd1);
            chk("proc_wr_addr", 32'(mem_addr_o), 32'd5);
         end
         if (k == 4) begin sobel_wr_en_i = 1'b0; sobel_addr_i = '0; end
         if (k == n_proc) sobel_finish_i = 1'b1;
         @(negedge clk_i);
      end
      sobel_finish_i = 1'b0;
      chk("drain_start_low", 32'(sobel_start_o), 32'd0);
      chk("start_cycles", nstart, n_proc);

      c = 0; acc = 0; first = -1; lastc = -1; maxo = 0; stl = 0; pd = '0; restart = 0;
      while (acc < PC && c < 300) begin
         px_ready_i = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
         if (wr_rd && c == 6) begin
            sobel_wr_en_i = 1'b1; sobel_addr_i = 8'd3; sobel_data = 8'hEE;
            #1;
            chk("rd_wr_blocked", 32'(mem_wr_en_o), 32'd0);
         end
         if (wr_rd && c == 7) begin
            sobel_wr_en_i = 1'b0; sobel_addr_i = '0;
            chk("err_set", 32'(err_o), 32'd1);
         end
         if (sobel_start_o) restart++;
         d = int'(mem_addr_o) - acc;
         if (d > maxo) maxo = d;
         if (stl) begin
            chk("stall_valid", 32'(px_valid_o), 32'd1);
            chk("stall_data", 32'(px_data_o), 32'(pd));
         end
         if (px_valid_o) begin
            if (first < 0) first = c;
            chk($sformatf("px_data[%0d]", acc), 32'(px_data_o), 32'(exp_px[acc]));
            chk($sformatf("px_last[%0d]", acc), 32'(px_last_o), 32'(acc == PC - 1));
         end
         stl = px_valid_o && !px_ready_i;
         pd  = px_data_o;
         if (px_valid_o && px_ready_i) begin acc++; lastc = c; end
         if (abort_at > 0 && acc == abort_at) break;
         @(negedge clk_i);
         c++;
      end
      // Two drain cycles plus two cycles of read latency before the first pixel.
      chk("first_latency", first, 4);
      chk("outstanding_le2", 32'(maxo <= 2), 32'd1);
      chk("no_restart", restart, 0);
      if (abort_at > 0) return;
      chk("pixels", acc, PC);
      if (mode == 0) chk("throughput", lastc - first, PC - 1);
      chk("done_pulse", 32'(done_o), 32'd1);
      chk("done_busy", 32'(busy_o), 32'd1);
      @(negedge clk_i);
      chk("done_clear", 32'(done_o), 32'd0);
      chk("idle", 32'(busy_o), 32'd0);
      if (wr_rd) chk("err_sticky", 32'(err_o), 32'd1);
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; sobel_finish_i = 1'b0; sobel_wr_en_i = 1'b0;
      sobel_addr_i = '0; sobel_data = '0; px_ready_i = 1'b0; mem_load = 1'b1;
      for (int i = 0; i < 16; i++) exp_px[i] = (i == 5) ? 8'hA5 : 8'h10 + 8'(i);
      do_reset();
      mem_load = 1'b0;
      @(negedge clk_i);

      start_i = 1'b1;
      run_frame(0, 1'b0, 1'b0, 0, 20);

      // Start held through the whole frame, stalled stream, illegal write in READ.
      start_i = 1'b1;
      run_frame(1, 1'b1, 1'b1, 0, 5);

      // Held start relaunches from IDLE; abort with reset after seven pixels.
      run_frame(0, 1'b0, 1'b0, 7, 6);
      do_reset();
      @(negedge clk_i);

      start_i = 1'b1;
      run_frame(0, 1'b0, 1'b0, 0, 20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
